// File: rtl/hcms_frame_arbiter.sv
// hcms_frame_arbiter: shares the HCMS29xx driver between two frame producers
// and one control-word producer. Control words win over frames; frames are
// granted round-robin. Each accepted transaction is registered and offered
// to the driver over a valid/ready handshake.
// Optional macro HCMS_ARB_HOLD_EN: adds a HOLD state that keeps the arbiter
// idle for HOLD_MIN cycles after every delivery.
module hcms_frame_arbiter #(
    parameter int N        = 2,
    parameter int UNIT_W   = 20,
    parameter int UNIT_H   = 8,
    parameter int HOLD_MIN = 16,
    localparam int FW      = N * UNIT_W * UNIT_H
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [FW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [FW-1:0] req1_data,
    output logic          req1_ready,
    input  logic          cmd_valid,
    input  logic [7:0]    cmd_data,
    output logic          cmd_ready,
    output logic          out_valid,
    output logic          out_is_cmd,
    output logic [FW-1:0] out_data,
    input  logic          out_ready,
    output logic [1:0]    grant,
    output logic [15:0]   frame_cnt
);

`ifdef HCMS_ARB_HOLD_EN
    localparam int HCW = (HOLD_MIN > 0) ? $clog2(HOLD_MIN + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        HOLD
    } state_t;

    logic [HCW-1:0] hold_q, hold_d;
`else
    typedef enum logic [1:0] {
        IDLE,
        OFFER
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [FW-1:0] data_q, data_d;
    logic          is_cmd_q, is_cmd_d;
    logic [1:0]    grant_q, grant_d;
    // rr_q = 1 means req1 wins a tie, 0 means req0 wins a tie
    logic          rr_q, rr_d;
    logic [15:0]   cnt_q, cnt_d;

    // State and payload registers; reset discards any in-flight transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            is_cmd_q <= 1'b0;
            grant_q  <= 2'b00;
            rr_q     <= 1'b0;
            cnt_q    <= '0;
`ifdef HCMS_ARB_HOLD_EN
            hold_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            is_cmd_q <= is_cmd_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
`ifdef HCMS_ARB_HOLD_EN
            hold_q   <= hold_d;
`endif
        end
    end

    // Arbitration, acceptance, handshake and next-state logic
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        is_cmd_d   = is_cmd_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        cmd_ready  = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
`ifdef HCMS_ARB_HOLD_EN
        hold_d     = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_ready = 1'b1;
                    data_d    = {{(FW-8){1'b0}}, cmd_data};
                    is_cmd_d  = 1'b1;
                    state_d   = OFFER;
                end else if (req0_valid && (!req1_valid || !rr_q)) begin
                    req0_ready = 1'b1;
                    data_d     = req0_data;
                    is_cmd_d   = 1'b0;
                    grant_d    = 2'b01;
                    rr_d       = 1'b1;
                    state_d    = OFFER;
                end else if (req1_valid) begin
                    req1_ready = 1'b1;
                    data_d     = req1_data;
                    is_cmd_d   = 1'b0;
                    grant_d    = 2'b10;
                    rr_d       = 1'b0;
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                if (out_ready) begin
                    if (!is_cmd_q) begin
                        cnt_d = cnt_q + 16'd1;
                    end
`ifdef HCMS_ARB_HOLD_EN
                    if (HOLD_MIN > 0) begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef HCMS_ARB_HOLD_EN
            HOLD: begin
                hold_d = hold_q + 1'b1;
                if (int'(hold_q) == HOLD_MIN - 1) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid  = (state_q == OFFER);
    assign out_is_cmd = is_cmd_q;
    assign out_data   = data_q;
    assign grant      = grant_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: doc/hcms_frame_arbiter.md
# hcms_frame_arbiter

Arbitrates access to the HCMS29xx serial display driver between two frame producers and one control-word producer. Each accepted transaction (full pixel frame or 8-bit control word) is registered and offered to the driver over a valid/ready handshake; control words take priority, frames are granted round-robin. An optional hold interval enforces minimum spacing between deliveries so the driver's idle/PWM phase is never starved.

## Interface
- N, 2, number of display units on the chain
- UNIT_W, 20, columns per unit
- UNIT_H, 8, rows per unit
- HOLD_MIN, 16, minimum idle cycles after each delivery (effective only with HCMS_ARB_HOLD_EN; 0 = no hold)
- FW (localparam), N*UNIT_W*UNIT_H, frame width in bits
- clk  in  1  fast system clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  producer 0 has a frame
- req0_data  in  FW  producer 0 frame
- req0_ready  out  1  producer 0 frame accepted this cycle when valid
- req1_valid / req1_data / req1_ready  same as producer 0
- cmd_valid  in  1  control word pending
- cmd_data  in  8  control word (CW0/CW1 format of the driver)
- cmd_ready  out  1  control word accepted this cycle when valid
- out_valid  out  1  registered transaction offered to driver
- out_is_cmd  out  1  1 = out_data[7:0] is a control word, 0 = pixel frame
- out_data  out  FW  payload; upper FW-8 bits zero for commands
- out_ready  in  1  driver takes the transaction
- grant  out  2  one-hot owner of current/last frame transaction (bit0 = req0)
- frame_cnt  out  16  frames delivered, wraps 0xFFFF -> 0

## Operation
- States: IDLE, OFFER, HOLD.
- IDLE: ready outputs combinational from state and valids; at most one ready high.
  - cmd_valid=1 -> cmd_ready=1 (priority over frames).
  - else if exactly one reqX_valid -> that reqX_ready=1.
  - else if both valid -> ready to the requester not granted last (rr pointer); pointer after reset favors req0.
- On acceptance edge: payload and out_is_cmd registered, grant updated (frame only; commands leave grant unchanged), rr pointer updated (frame only), state -> OFFER.
- OFFER: out_valid=1; out_data/out_is_cmd/grant stable; all *_ready=0. out_ready=1 at edge -> frame_cnt+1 if frame; state -> HOLD if HCMS_ARB_HOLD_EN and HOLD_MIN>0, else IDLE.
- HOLD: counter loads 0 on entry, increments each cycle; all *_ready=0; after HOLD_MIN cycles (counter==HOLD_MIN-1) -> IDLE.
- Counter width $clog2(HOLD_MIN+1); frame_cnt 16-bit unsigned wrap.
- Producer deasserting valid without ready: no transfer, no state change.
- Simultaneous cmd_valid and both req valid: cmd served first; the frame arbitration happens at the next IDLE with the unchanged pointer.
- Reset (any time, including mid-OFFER): state=IDLE, out_valid=0, out_is_cmd=0, out_data=0, grant=2'b00, frame_cnt=0, hold counter=0, rr pointer favors req0; in-flight transaction discarded.

## Timing
- Acceptance at edge k -> out_valid=1 from k (registered, visible cycle k+1).
- Minimum issue interval without hold: 2 cycles (accept, offer+handshake) when out_ready held 1.
- With hold: 2+HOLD_MIN cycles per transaction.
- *_ready are combinational; valids must be stable before clk edge; no combinational path from out_ready to any *_ready.
- out_valid never drops without out_ready (except reset).

## Configuration
- HCMS_ARB_HOLD_EN defined: HOLD state and counter present; HOLD_MIN enforced after every delivered transaction (frame or command).
- Undefined: HOLD state and counter removed; OFFER returns directly to IDLE; HOLD_MIN ignored.

## Test plan
- Reset then req0_valid=1, data=0x...A5 -> req0_ready=1 same cycle, next cycle out_valid=1, out_is_cmd=0, grant=01, out_data=payload; out_ready=1 -> frame_cnt=1.
- req0 and req1 both valid continuously, out_ready=1 -> grants alternate 01,10,01,10; frame_cnt=4 after four handshakes.
- cmd_valid with cmd_data=0x4F and both reqs valid -> command first (out_is_cmd=1, out_data=0x4F, grant unchanged), then req0.
- HCMS_ARB_HOLD_EN, HOLD_MIN=16, out_ready=1 -> consecutive out_valid rising edges exactly 18 cycles apart; all ready low during hold.
- out_ready=0 for 50 cycles -> out_valid and out_data stable, no ready asserted; then out_ready=1 -> single delivery.
- Assert rst during OFFER -> out_valid=0 immediately, frame_cnt=0, grant=00; after release req1 and req0 both valid -> req0 served first.
